// File: rtl/ffnn_layer_seq_if.sv
// Handshake and parameter-write bundle for one ffnn_layer_seq instance.
interface ffnn_layer_seq_if #(
  parameter int DATA_W = 8,
  parameter int N_IN   = 4,
  parameter int N_OUT  = 3
);
  localparam int NPAR = N_OUT * (N_IN + 1);
  localparam int AW   = (NPAR > 1) ? $clog2(NPAR) : 1;

  logic                     w_we;
  logic [AW-1:0]            w_addr;
  logic signed [DATA_W-1:0] w_data;
  logic                     w_ack;
  logic                     in_valid;
  logic                     in_ready;
  logic [N_IN*DATA_W-1:0]   in_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [N_OUT*DATA_W-1:0]  out_data;
  logic                     busy;

  modport master (
    output w_we, w_addr, w_data, in_valid, in_data, out_ready,
    input  w_ack, in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  w_we, w_addr, w_data, in_valid, in_data, out_ready,
    output w_ack, in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/ffnn_layer_seq.sv
// Sequential fully-connected layer: one shared MAC walks every neuron/input pair,
// then the saturated (optionally ReLU'd) results are held until downstream accepts.
module ffnn_layer_seq #(
  parameter int DATA_W = 8,
  parameter int N_IN   = 4,
  parameter int N_OUT  = 3,
  parameter int ACC_W  = 2*DATA_W + $clog2(N_IN) + 1,
  parameter bit RELU   = 1'b1
) (
  input logic              clk,
  input logic              rst_n,
  ffnn_layer_seq_if.slave  bus
);
  localparam int NPAR = N_OUT * (N_IN + 1);
  localparam int AW   = (NPAR > 1) ? $clog2(NPAR) : 1;
  localparam int IW   = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int JW   = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam int PW   = 2 * DATA_W;

  localparam logic signed [ACC_W-1:0] Y_MAX = ACC_W'((2 ** (DATA_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] Y_MIN = ~Y_MAX;

  typedef enum logic [1:0] {IDLE, MAC, ACT, DONE} state_e;

  state_e                    state_q, state_d;
  logic [IW-1:0]             i_q, i_d;
  logic [JW-1:0]             j_q, j_d;
  logic signed [DATA_W-1:0]  x_q [N_IN];
  logic signed [DATA_W-1:0]  p_q [NPAR];
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic signed [DATA_W-1:0]  y_q [N_OUT];
  logic                      w_ack_q;

  logic                      accept;
  logic                      wr_ok;
  logic                      i_last, j_last;
  logic [AW-1:0]             widx, bidx;
  logic signed [PW-1:0]      prod;

  function automatic logic signed [ACC_W-1:0] act_f(input logic signed [ACC_W-1:0] a);
    if (RELU && a[ACC_W-1]) return '0;
    return a;
  endfunction

  function automatic logic signed [DATA_W-1:0] sat_f(input logic signed [ACC_W-1:0] a);
    if (a > Y_MAX) return Y_MAX[DATA_W-1:0];
    if (a < Y_MIN) return Y_MIN[DATA_W-1:0];
    return a[DATA_W-1:0];
  endfunction

  assign i_last = (i_q == IW'(N_IN - 1));
  assign j_last = (j_q == JW'(N_OUT - 1));

  // Parameter writes only land while idle and in range; a same-cycle accept sees them on the next edge.
  assign wr_ok = bus.w_we && (state_q == IDLE) &&
                 ({1'b0, bus.w_addr} < (AW+1)'(NPAR));

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          accept  = 1'b1;
          state_d = MAC;
          i_d     = '0;
          j_d     = '0;
        end
      end
      MAC: begin
        if (i_last) begin
          i_d = '0;
          if (j_last) begin
            j_d     = '0;
            state_d = ACT;
          end else begin
            j_d = j_q + JW'(1);
          end
        end else begin
          i_d = i_q + IW'(1);
        end
      end
      ACT:     state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      i_q     <= '0;
      j_q     <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
    end
  end

  // Bias for neuron j sits after all weights in the register file.
  always_comb begin
    widx  = AW'(j_q) * AW'(N_IN) + AW'(i_q);
    bidx  = AW'(N_OUT * N_IN) + AW'(j_q);
    prod  = PW'(x_q[i_q]) * PW'(p_q[widx]);
    acc_d = ((i_q == '0) ? ACC_W'(p_q[bidx]) : acc_q) + ACC_W'(prod);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q   <= '0;
      w_ack_q <= 1'b0;
      for (int k = 0; k < NPAR; k++) p_q[k] <= '0;
      for (int k = 0; k < N_OUT; k++) y_q[k] <= '0;
    end else begin
      w_ack_q <= wr_ok;
      if (wr_ok) p_q[bus.w_addr] <= bus.w_data;
      if (state_q == MAC) begin
        acc_q <= acc_d;
        if (i_last) y_q[j_q] <= sat_f(act_f(acc_d));
      end
    end
  end

  // The input buffer decouples the result from in_data after acceptance.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int k = 0; k < N_IN; k++) x_q[k] <= bus.in_data[k*DATA_W +: DATA_W];
    end
  end

  for (genvar g = 0; g < N_OUT; g++) begin : g_out
    assign bus.out_data[g*DATA_W +: DATA_W] = y_q[g];
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q == MAC) || (state_q == ACT);
  assign bus.w_ack     = w_ack_q;
endmodule

// File: tb/tb_ffnn_layer_seq.sv
// Randomised bench for ffnn_layer_seq: a ReLU and an identity instance run in lockstep
// against a plain-arithmetic layer model.
module tb_ffnn_layer_seq;
  localparam int DW = 8;
  localparam int NI = 4;
  localparam int NO = 3;
  localparam int NP = NO * (NI + 1);
  localparam int LAT = NO * NI + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ffnn_layer_seq_if #(.DATA_W(DW), .N_IN(NI), .N_OUT(NO)) br ();
  ffnn_layer_seq_if #(.DATA_W(DW), .N_IN(NI), .N_OUT(NO)) bl ();

  ffnn_layer_seq #(.DATA_W(DW), .N_IN(NI), .N_OUT(NO), .RELU(1'b1)) u_relu (
    .clk(clk), .rst_n(rst_n), .bus(br));
  ffnn_layer_seq #(.DATA_W(DW), .N_IN(NI), .N_OUT(NO), .RELU(1'b0)) u_lin (
    .clk(clk), .rst_n(rst_n), .bus(bl));

  int n_chk = 0;
  int n_err = 0;
  int wm [NP];
  int xm [NI];
  int got_r [NO];
  int got_l [NO];

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int ref_y(input int j, input bit relu);
    int s;
    s = wm[NO*NI + j];
    for (int i = 0; i < NI; i++) s += xm[i] * wm[j*NI + i];
    if (relu && s < 0) s = 0;
    if (s > 127) s = 127;
    if (s < -128) s = -128;
    return s;
  endfunction

  function automatic logic [NI*DW-1:0] pack_x();
    logic [NI*DW-1:0] p;
    for (int i = 0; i < NI; i++) p[i*DW +: DW] = DW'(xm[i]);
    return p;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_w(input bit we, input int addr, input int data);
    br.w_we = we;  br.w_addr = 4'(addr);  br.w_data = DW'(data);
    bl.w_we = we;  bl.w_addr = 4'(addr);  bl.w_data = DW'(data);
  endtask

  task automatic set_in(input bit v, input logic [NI*DW-1:0] d);
    br.in_valid = v;  br.in_data = d;
    bl.in_valid = v;  bl.in_data = d;
  endtask

  task automatic set_ordy(input bit r);
    br.out_ready = r;
    bl.out_ready = r;
  endtask

  task automatic wr(input int addr, input int data);
    set_w(1'b1, addr, data);
    step();
    set_w(1'b0, 0, 0);
    chk("w_ack_r", int'(br.w_ack), 1);
    chk("w_ack_l", int'(bl.w_ack), 1);
    wm[addr] = data;
  endtask

  task automatic launch(input string tag);
    int k;
    set_in(1'b1, pack_x());
    k = 0;
    while (!(br.in_ready && bl.in_ready) && k < 50) begin
      step();
      k++;
    end
    chk({tag, "_in_ready"}, int'(br.in_ready && bl.in_ready), 1);
    step();
    set_in(1'b0, {$urandom, $urandom});
  endtask

  task automatic collect(input string tag, input int cyc0);
    int cyc;
    cyc = cyc0;
    while (!(br.out_valid && bl.out_valid) && cyc < 100) begin
      step();
      cyc++;
      if (cyc == 6) chk({tag, "_busy"}, int'(br.busy && bl.busy), 1);
    end
    chk({tag, "_latency"}, cyc, LAT);
    for (int j = 0; j < NO; j++) begin
      got_r[j] = int'($signed(br.out_data[j*DW +: DW]));
      got_l[j] = int'($signed(bl.out_data[j*DW +: DW]));
      chk({tag, "_y_relu"}, got_r[j], ref_y(j, 1'b1));
      chk({tag, "_y_lin"}, got_l[j], ref_y(j, 1'b0));
    end
  endtask

  task automatic release_out(input string tag);
    set_ordy(1'b1);
    step();
    set_ordy(1'b0);
    chk({tag, "_vld_drop"}, int'(br.out_valid || bl.out_valid), 0);
    chk({tag, "_idle_rdy"}, int'(br.in_ready && bl.in_ready), 1);
  endtask

  initial begin
    int exp_r [NO];
    int exp_l [NO];
    int seen;

    set_w(1'b0, 0, 0);
    set_in(1'b0, '0);
    set_ordy(1'b0);
    for (int a = 0; a < NP; a++) wm[a] = 0;

    rst_n = 1'b0;
    step();
    step();
    chk("rst_in_ready", int'(br.in_ready && bl.in_ready), 1);
    chk("rst_out_valid", int'(br.out_valid || bl.out_valid), 0);
    chk("rst_busy", int'(br.busy || bl.busy), 0);
    chk("rst_w_ack", int'(br.w_ack || bl.w_ack), 0);
    chk("rst_out_data", int'(br.out_data | bl.out_data), 0);
    rst_n = 1'b1;
    step();

    // Reference vector
    for (int i = 0; i < NI; i++) begin
      wr(0*NI + i, (i == 3) ? -1 : 1);
      wr(1*NI + i, 2);
      wr(2*NI + i, (i == 0) ? -3 : 3);
    end
    for (int j = 0; j < NO; j++) wr(NO*NI + j, 1);
    xm = '{1, 3, -2, 3};
    launch("t1");
    collect("t1", 0);
    chk("t1_y0", got_r[0], 0);
    chk("t1_y1", got_r[1], 11);
    chk("t1_y2", got_r[2], 10);
    release_out("t1");

    wr(3, -3);
    launch("t2");
    collect("t2", 0);
    release_out("t2");

    // Saturation at both rails
    for (int a = 0; a < NP; a++) wr(a, 127);
    xm = '{127, 127, 127, 127};
    launch("t3a");
    collect("t3a", 0);
    for (int j = 0; j < NO; j++) chk("t3a_sat_hi", got_r[j], 127);
    release_out("t3a");
    for (int j = 0; j < NO; j++) wr(NO*NI + j, -128);
    xm = '{-128, -128, -128, -128};
    launch("t3b");
    collect("t3b", 0);
    for (int j = 0; j < NO; j++) begin
      chk("t3b_sat_lo", got_l[j], -128);
      chk("t3b_relu", got_r[j], 0);
    end
    release_out("t3b");

    // Backpressure with a follow-up vector waiting
    for (int a = 0; a < NP; a++) wr(a, int'($urandom_range(0, 255)) - 128);
    for (int i = 0; i < NI; i++) xm[i] = int'($urandom_range(0, 255)) - 128;
    launch("t4a");
    collect("t4a", 0);
    for (int j = 0; j < NO; j++) begin
      exp_r[j] = ref_y(j, 1'b1);
      exp_l[j] = ref_y(j, 1'b0);
    end
    for (int i = 0; i < NI; i++) xm[i] = int'($urandom_range(0, 255)) - 128;
    set_in(1'b1, pack_x());
    for (int c = 0; c < 5; c++) begin
      step();
      chk("t4_hold_vld", int'(br.out_valid && bl.out_valid), 1);
      chk("t4_hold_rdy", int'(br.in_ready || bl.in_ready), 0);
      for (int j = 0; j < NO; j++) begin
        chk("t4_hold_r", int'($signed(br.out_data[j*DW +: DW])), exp_r[j]);
        chk("t4_hold_l", int'($signed(bl.out_data[j*DW +: DW])), exp_l[j]);
      end
    end
    release_out("t4");
    step();
    set_in(1'b0, {$urandom, $urandom});
    chk("t4_accepted", int'(br.busy && bl.busy && !br.in_ready && !bl.in_ready), 1);
    collect("t4b", 0);
    release_out("t4b");

    // Writes outside IDLE or out of range are dropped
    for (int i = 0; i < NI; i++) xm[i] = int'($urandom_range(0, 255)) - 128;
    launch("t5");
    step();
    step();
    step();
    set_w(1'b1, 0, 99);
    step();
    set_w(1'b0, 0, 0);
    chk("t5_mac_wack", int'(br.w_ack || bl.w_ack), 0);
    collect("t5", 4);
    release_out("t5");
    set_w(1'b1, 15, 55);
    step();
    set_w(1'b0, 0, 0);
    chk("t5_oor_wack", int'(br.w_ack || bl.w_ack), 0);

    for (int t = 0; t < 15; t++) begin
      for (int a = 0; a < NP; a++) wr(a, int'($urandom_range(0, 255)) - 128);
      for (int i = 0; i < NI; i++) xm[i] = int'($urandom_range(0, 255)) - 128;
      launch("rnd");
      collect("rnd", 0);
      release_out("rnd");
    end

    // Reset in the middle of MAC
    for (int i = 0; i < NI; i++) xm[i] = int'($urandom_range(0, 255)) - 128;
    launch("t6");
    for (int c = 0; c < 5; c++) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("t6_in_ready", int'(br.in_ready && bl.in_ready), 1);
    chk("t6_busy", int'(br.busy || bl.busy), 0);
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      if (br.out_valid || bl.out_valid) seen = 1;
      step();
    end
    chk("t6_no_valid", seen, 0);
    for (int a = 0; a < NP; a++) wm[a] = 0;
    for (int i = 0; i < NI; i++) xm[i] = int'($urandom_range(0, 255)) - 128;
    launch("t6z");
    collect("t6z", 0);
    release_out("t6z");

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
